serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock from the operand LSBs upward.
// Result and carry-out are registered and held until the next addition completes.
module serial_adder #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state, state_next;
   logic [N-1:0]   a_sr, b_sr, psum, psum_next;
   logic           carry, carry_next, bit_sum;
   logic [CW-1:0]  cnt;
   logic           load, step, last;

   // Next-state decode plus the one-bit full adder feeding the partial sum
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      bit_sum    = a_sr[0] ^ b_sr[0] ^ carry;
      carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
      psum_next  = (psum >> 1) | (N'(bit_sum) << (N - 1));
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == CW'(N - 1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         psum  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         busy  <= (state_next == SHIFT);
         done  <= (state_next == DONE);
         if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            psum  <= '0;
            carry <= cin;
            cnt   <= '0;
         end
         if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            psum  <= psum_next;
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
         end
         // Final bit: publish the completed sum directly from the adder path
         if (last) begin
            sum  <= psum_next;
            cout <= carry_next;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at N=8, plus a small N=1 instance.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst, start, cin, busy, done, cout;
   logic [7:0] a, b, sum;
   logic       start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_adder #(.N(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   // Drives one start pulse and observes the resulting operation (no checking here)
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output logic [7:0] rs, output logic rc, output int lat,
                         output int busy_cnt, output logic overlap, output logic stable,
                         output logic done_after);
      logic [7:0] s0;
      logic       c0;
      @(negedge clk);
      a = ia; b = ib; cin = ic; start = 1'b1;
      s0 = sum; c0 = cout;
      @(negedge clk);
      start = 1'b0;
      lat = 1; busy_cnt = 0; stable = 1'b1;
      while (!done && lat < 50) begin
         if (busy) busy_cnt++;
         if (sum !== s0 || cout !== c0) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      overlap = busy & done;
      rs = sum; rc = cout;
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({busy, done, cout, sum} !== 11'h000) begin failures++; $display("FAIL reset8 got=%0h exp=0", {busy, done, cout, sum}); end
      checks++; if ({busy1, done1, cout1, sum1} !== 4'h0) begin failures++; $display("FAIL reset1 got=%0h exp=0", {busy1, done1, cout1, sum1}); end
      rst = 1'b0; start = 1'b0; start1 = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%0b exp=0", busy); end
   endtask

   task automatic test_basic();
      logic [7:0] rs; logic rc, ov, st, da; int lat, bc;
      run_op(8'hFF, 8'h01, 1'b0, rs, rc, lat, bc, ov, st, da);
      checks++; if (rs !== 8'h00) begin failures++; $display("FAIL basic_sum got=%0h exp=00", rs); end
      checks++; if (rc !== 1'b1) begin failures++; $display("FAIL basic_cout got=%0b exp=1", rc); end
      checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
      checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL basic_busy_done_overlap got=%0b exp=0", ov); end
      checks++; if (da !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%0b exp=0", da); end
   endtask

   task automatic test_hold();
      logic [7:0] rs; logic rc, ov, st, da; int lat, bc;
      run_op(8'hA5, 8'h5A, 1'b1, rs, rc, lat, bc, ov, st, da);
      checks++; if ({rc, rs} !== 9'h100) begin failures++; $display("FAIL hold_first got=%0h exp=100", {rc, rs}); end
      run_op(8'h3C, 8'h42, 1'b0, rs, rc, lat, bc, ov, st, da);
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL hold_stable_during_shift got=%0b exp=1", st); end
      checks++; if ({rc, rs} !== 9'h07E) begin failures++; $display("FAIL hold_second got=%0h exp=07e", {rc, rs}); end
   endtask

   task automatic test_ignore();
      logic [7:0] rs; logic rc, ov, st, da; int lat, bc, n;
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h11; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL ignore_done_seen got=%0b exp=1", done); end
      start = 1'b1;
      checks++; if ({cout, sum} !== 9'h030) begin failures++; $display("FAIL ignore_sum got=%0h exp=030", {cout, sum}); end
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_done_start busy got=%0b exp=0", busy); end
      checks++; if ({cout, sum} !== 9'h030) begin failures++; $display("FAIL ignore_sum_held got=%0h exp=030", {cout, sum}); end
      run_op(8'h11, 8'h11, 1'b0, rs, rc, lat, bc, ov, st, da);
      checks++; if ({rc, rs} !== 9'h022) begin failures++; $display("FAIL ignore_next_accept got=%0h exp=022", {rc, rs}); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] rs; logic rc, ov, st, da; int lat, bc, d;
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL abort_flags got=%0b exp=00", {busy, done}); end
      checks++; if ({cout, sum} !== 9'h000) begin failures++; $display("FAIL abort_sum got=%0h exp=000", {cout, sum}); end
      d = 0;
      repeat (12) begin @(negedge clk); if (done) d++; end
      checks++; if (d !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", d); end
      run_op(8'h80, 8'h80, 1'b0, rs, rc, lat, bc, ov, st, da);
      checks++; if ({rc, rs} !== 9'h100) begin failures++; $display("FAIL abort_restart got=%0h exp=100", {rc, rs}); end
   endtask

   task automatic test_back_to_back();
      int t, last_t, pulses, n;
      @(negedge clk);
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      t = 0; last_t = -1; pulses = 0;
      repeat (45) begin
         @(negedge clk);
         t++;
         if (done) begin
            checks++; if ({cout, sum} !== 9'h003) begin failures++; $display("FAIL b2b_sum got=%0h exp=003", {cout, sum}); end
            if (last_t >= 0) begin
               checks++; if (t - last_t !== 10) begin failures++; $display("FAIL b2b_period got=%0d exp=10", t - last_t); end
            end
            last_t = t;
            pulses++;
         end
      end
      start = 1'b0;
      checks++; if (pulses !== 4) begin failures++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
      n = 0;
      while ((busy || done) && n < 30) begin @(negedge clk); n++; end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb, rs; logic rcin, rc, ov, st, da; int lat, bc;
      logic [8:0] exp9;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rcin = 1'($urandom_range(0, 1));
         exp9 = 9'(ra) + 9'(rb) + 9'(rcin);
         run_op(ra, rb, rcin, rs, rc, lat, bc, ov, st, da);
         checks++; if ({rc, rs} !== exp9) begin failures++; $display("FAIL rand_sum a=%0h b=%0h c=%0b got=%0h exp=%0h", ra, rb, rcin, {rc, rs}, exp9); end
         checks++; if (lat !== 9) begin failures++; $display("FAIL rand_latency got=%0d exp=9", lat); end
         checks++; if (da !== 1'b0) begin failures++; $display("FAIL rand_done_width got=%0b exp=0", da); end
      end
   endtask

   task automatic test_n1();
      logic [1:0] exp2;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a1 = 1'(i & 1); b1 = 1'((i >> 1) & 1); cin1 = 1'((i >> 2) & 1);
         exp2 = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         checks++; if ({busy1, done1} !== 2'b10) begin failures++; $display("FAIL n1_shift got=%0b exp=10", {busy1, done1}); end
         @(negedge clk);
         checks++; if ({busy1, done1} !== 2'b01) begin failures++; $display("FAIL n1_done got=%0b exp=01", {busy1, done1}); end
         checks++; if ({cout1, sum1} !== exp2) begin failures++; $display("FAIL n1_sum i=%0d got=%0h exp=%0h", i, {cout1, sum1}, exp2); end
         @(negedge clk);
         checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL n1_done_width got=%0b exp=0", done1); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_ignore();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_n1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
